// File: rtl/axis_master_arbiter.sv
// Round-robin packet arbiter in front of a single axis_master backend port.
// A grant covers a whole packet and is held until the backend reports bk_done.
module axis_master_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter logic [7:0]  DRAIN_TIMEOUT = 8'd255
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_last,
    input  logic [32*N_REQ-1:0]  req_data,
    input  logic [4*N_REQ-1:0]   req_tstrb,
    input  logic [4*N_REQ-1:0]   req_tkeep,
    input  logic [2*N_REQ-1:0]   req_user,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 bk_start,
    output logic [31:0]          bk_data,
    output logic [3:0]           bk_tstrb,
    output logic [3:0]           bk_tkeep,
    output logic [1:0]           bk_user,
    input  logic                 bk_nordy,
    input  logic                 bk_done,
    output logic [2:0]           grant_id,
    output logic                 busy,
    input  logic                 err_clr,
    output logic                 drain_to_err,
    output logic                 frag_err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_gnt_q, last_gnt_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic        bk_start_q, bk_start_d;
    logic [31:0] bk_data_q, bk_data_d;
    logic [3:0]  bk_tstrb_q, bk_tstrb_d;
    logic [3:0]  bk_tkeep_q, bk_tkeep_d;
    logic [1:0]  bk_user_q, bk_user_d;
    logic        drain_err_q, drain_err_d;
    logic        frag_err_q, frag_err_d;

    // Requester signals widened to 8 lanes so a 3-bit grant indexes them exactly.
    logic [7:0]  valid_ext;
    logic [7:0]  last_ext;
    logic [31:0] data_arr [8];
    logic [3:0]  strb_arr [8];
    logic [3:0]  keep_arr [8];
    logic [1:0]  user_arr [8];

    always_comb begin
        valid_ext = '0;
        last_ext  = '0;
        for (int i = 0; i < 8; i++) begin
            data_arr[i] = '0;
            strb_arr[i] = '0;
            keep_arr[i] = '0;
            user_arr[i] = '0;
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            valid_ext[i] = req_valid[i];
            last_ext[i]  = req_last[i];
            data_arr[i]  = req_data[32*i +: 32];
            strb_arr[i]  = req_tstrb[4*i +: 4];
            keep_arr[i]  = req_tkeep[4*i +: 4];
            user_arr[i]  = req_user[2*i +: 2];
        end
    end

    // Search starts one past the previous winner and wraps at N_REQ.
    logic       found;
    logic [2:0] pick;
    logic [3:0] cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = {1'b0, last_gnt_q} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!found && valid_ext[cand[2:0]]) begin
                found = 1'b1;
                pick  = cand[2:0];
            end
        end
    end

    logic [7:0] ready_ext;
    logic       accept;

    always_comb begin
        ready_ext = 8'd0;
        if (state_q == StGrant && !bk_nordy) begin
            ready_ext = 8'd1 << grant_q;
        end
    end

    assign req_ready = ready_ext[N_REQ-1:0];
    assign accept    = (state_q == StGrant) && valid_ext[grant_q] && !bk_nordy;
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        bk_start_d  = 1'b0;
        bk_data_d   = bk_data_q;
        bk_tstrb_d  = bk_tstrb_q;
        bk_tkeep_d  = bk_tkeep_q;
        bk_user_d   = bk_user_q;
        drain_err_d = drain_err_q & ~err_clr;
        frag_err_d  = frag_err_q & ~err_clr;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (found) begin
                    grant_d    = pick;
                    last_gnt_d = pick;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (accept) begin
                    bk_start_d = 1'b1;
                    bk_data_d  = data_arr[grant_q];
                    bk_tstrb_d = strb_arr[grant_q];
                    bk_tkeep_d = keep_arr[grant_q];
                    bk_user_d  = user_arr[grant_q];
                    if (last_ext[grant_q]) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                    end
                end
                // A done mid-packet means the backend closed the packet early.
                if (bk_done) begin
                    frag_err_d = 1'b1;
                end
            end
            StDrain: begin
                if (bk_done) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_inc >= DRAIN_TIMEOUT) begin
                    drain_err_d = 1'b1;
                    state_d     = StIdle;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_gnt_q  <= 3'(N_REQ - 1);
            cnt_q       <= '0;
            bk_start_q  <= 1'b0;
            bk_data_q   <= '0;
            bk_tstrb_q  <= '0;
            bk_tkeep_q  <= '0;
            bk_user_q   <= '0;
            drain_err_q <= 1'b0;
            frag_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            bk_start_q  <= bk_start_d;
            bk_data_q   <= bk_data_d;
            bk_tstrb_q  <= bk_tstrb_d;
            bk_tkeep_q  <= bk_tkeep_d;
            bk_user_q   <= bk_user_d;
            drain_err_q <= drain_err_d;
            frag_err_q  <= frag_err_d;
        end
    end

    assign bk_start     = bk_start_q;
    assign bk_data      = bk_data_q;
    assign bk_tstrb     = bk_tstrb_q;
    assign bk_tkeep     = bk_tkeep_q;
    assign bk_user      = bk_user_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q != StIdle);
    assign drain_to_err = drain_err_q;
    assign frag_err     = frag_err_q;

endmodule

// File: tb/tb_axis_master_arbiter.sv
// Scoreboard bench for axis_master_arbiter: per-requester source queues feed the DUT,
// expected backend beats (with grant id) are queued at send time and popped on bk_start.
module tb_axis_master_arbiter;

    logic         axi_aclk = 1'b0;
    logic         axi_areset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_last = '0;
    logic [127:0] req_data = '0;
    logic [15:0]  req_tstrb = '0;
    logic [15:0]  req_tkeep = '0;
    logic [7:0]   req_user = '0;
    logic [3:0]   req_ready;
    logic         bk_start;
    logic [31:0]  bk_data;
    logic [3:0]   bk_tstrb;
    logic [3:0]   bk_tkeep;
    logic [1:0]   bk_user;
    logic         bk_nordy = 1'b0;
    logic         bk_done = 1'b0;
    logic [2:0]   grant_id;
    logic         busy;
    logic         err_clr = 1'b0;
    logic         drain_to_err;
    logic         frag_err;

    axis_master_arbiter #(
        .N_REQ         (4),
        .DRAIN_TIMEOUT (8'd10)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_areset   (axi_areset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_tstrb    (req_tstrb),
        .req_tkeep    (req_tkeep),
        .req_user     (req_user),
        .req_ready    (req_ready),
        .bk_start     (bk_start),
        .bk_data      (bk_data),
        .bk_tstrb     (bk_tstrb),
        .bk_tkeep     (bk_tkeep),
        .bk_user      (bk_user),
        .bk_nordy     (bk_nordy),
        .bk_done      (bk_done),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_clr      (err_clr),
        .drain_to_err (drain_to_err),
        .frag_err     (frag_err)
    );

    always #5 axi_aclk = ~axi_aclk;

    // Source beat: {last, user[1:0], keep[3:0], strb[3:0], data[31:0]}
    logic [42:0] src_q [4][$];
    // Expected backend beat: {grant[2:0], user, keep, strb, data}
    logic [44:0] exp_q [$];
    logic [3:0]  acc = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          starts = 0;
    int          done_cnt = 0;
    bit          auto_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_pkt(input int r, input int n, input logic [31:0] base);
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  k;
        logic [1:0]  u;
        for (int j = 0; j < n; j++) begin
            d = base * 32'(j + 1);
            s = 4'(j + 1);
            k = ~s;
            u = 2'(j + r);
            src_q[r].push_back({(j == n - 1), u, k, s, d});
            exp_q.push_back({3'(r), u, k, s, d});
        end
    endtask

    // One clock: monitor backend output, retire accepted beats, drive next inputs,
    // then record which requesters will be accepted at the coming edge.
    task automatic cycle(input logic nordy, input logic done, input logic clr);
        logic [42:0] b;
        logic [44:0] e;
        logic        dn;
        @(negedge axi_aclk);
        cyc++;
        if (bk_start) begin
            starts++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'({grant_id, bk_user, bk_tkeep, bk_tstrb, bk_data}), 64'(e));
            end
        end
        dn = done;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) dn = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                if (b[42] && auto_done) done_cnt = 2;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                req_valid[i]         = 1'b1;
                req_last[i]          = b[42];
                req_user[2*i +: 2]   = b[41:40];
                req_tkeep[4*i +: 4]  = b[39:36];
                req_tstrb[4*i +: 4]  = b[35:32];
                req_data[32*i +: 32] = b[31:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_user[2*i +: 2]   = '0;
                req_tkeep[4*i +: 4]  = '0;
                req_tstrb[4*i +: 4]  = '0;
                req_data[32*i +: 32] = '0;
            end
        end
        bk_nordy = nordy;
        bk_done  = dn;
        err_clr  = clr;
        #1;
        acc = req_valid & req_ready;
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        acc      = '0;
        done_cnt = 0;
    endtask

    task automatic do_reset();
        axi_areset = 1'b1;
        flush();
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        axi_areset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, 64'({bk_start, bk_data, bk_tstrb, bk_tkeep, bk_user, grant_id, busy,
                        req_ready, drain_to_err, frag_err}), 64'd0);
    endtask

    task automatic wait_starts(input int target, input string tag);
        int n = 0;
        while (starts < target && n < 50) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        check(tag, 64'(starts >= target), 64'd1);
    endtask

    task automatic run_until_idle(input string tag);
        int  n = 0;
        bit  pend;
        pend = 1'b1;
        while (pend && n < 200) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
            pend = busy || exp_q.size() != 0 || done_cnt != 0;
            for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) pend = 1'b1;
        end
        check(tag, 64'(pend), 64'd0);
    endtask

    initial begin
        int s0;
        int c1;
        int n;

        // Reset values
        do_reset();
        check_reset_vals("reset_outputs");

        // Single requester, 3 back-to-back beats, manual bk_done
        auto_done = 1'b0;
        s0 = starts;
        send_pkt(0, 3, 32'h11);
        wait_starts(s0 + 1, "t1_first_start");
        c1 = cyc;
        wait_starts(s0 + 3, "t1_all_starts");
        check("t1_consecutive", 64'(cyc - c1), 64'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("t1_drain_hold", 64'(busy), 64'd1);
        end
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("t1_idle_after_done", 64'(busy), 64'd0);

        // Backpressure: 4-beat packet, 4 stalled cycles mid-packet
        auto_done = 1'b1;
        s0 = starts;
        send_pkt(2, 4, 32'hA000_0003);
        wait_starts(s0 + 1, "bp_first_start");
        cycle(1'b1, 1'b0, 1'b0);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        c1 = starts;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("bp_ready_low", 64'(req_ready), 64'd0);
        end
        cycle(1'b0, 1'b0, 1'b0);
        check("bp_no_start", 64'(starts - c1), 64'd0);
        run_until_idle("bp_complete");

        // Drain timeout with a single-beat packet and no bk_done
        auto_done = 1'b0;
        s0 = starts;
        send_pkt(1, 1, 32'h5A5A_0001);
        wait_starts(s0 + 1, "to_start");
        n = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (!busy) break;
            n++;
        end
        check("to_drain_cycles", 64'(n), 64'd10);
        check("to_err_set", 64'({drain_to_err, frag_err}), 64'b10);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("to_err_clr", 64'(drain_to_err), 64'd0);

        // Fragmentation: bk_done during GRANT (with a simultaneous clear: set wins)
        auto_done = 1'b1;
        s0 = starts;
        send_pkt(3, 3, 32'h0C0C_0303);
        wait_starts(s0 + 1, "frag_start");
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("frag_set", 64'({frag_err, busy}), 64'b11);
        run_until_idle("frag_complete");
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("frag_clr", 64'(frag_err), 64'd0);

        // Round robin: 0, 1, 3 with two 2-beat packets each
        do_reset();
        auto_done = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            send_pkt(0, 2, 32'h1000_0000 + 32'(rep));
            send_pkt(1, 2, 32'h2000_0000 + 32'(rep));
            send_pkt(3, 2, 32'h3000_0000 + 32'(rep));
        end
        run_until_idle("rr_complete");

        // Reset in the middle of a 3-beat packet
        s0 = starts;
        send_pkt(2, 3, 32'h0000_7777);
        wait_starts(s0 + 1, "mid_start");
        axi_areset = 1'b1;
        flush();
        cycle(1'b0, 1'b0, 1'b0);
        check_reset_vals("mid_reset_outputs");
        axi_areset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check("mid_no_start", 64'({bk_start, busy}), 64'd0);
        send_pkt(0, 2, 32'h0000_0B0B);
        send_pkt(3, 2, 32'h0000_0D0D);
        run_until_idle("mid_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
